// File: rtl/ov_cam_pkg.sv
// Shared types and pixel-format conversion for the camera window capture.
// Latency: combinational helpers only.
// Backpressure: none; pure types and functions.
package ov_cam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } cap_state_e;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_YUV_Y  = 2'd2,
        MODE_RSVD   = 2'd3
    } pix_mode_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Narrow channels are widened by replicating their MSBs so full scale stays full scale.
    function automatic rgb565_t to_rgb565(input pix_mode_e mode, input logic [15:0] pix);
        rgb565_t c;
        case (mode)
            MODE_RGB444: c = rgb565_t'({pix[11:8], pix[11], pix[7:4], pix[7:6], pix[3:0], pix[3]});
            MODE_YUV_Y:  c = rgb565_t'({pix[15:11], pix[15:10], pix[15:11]});
            default:     c = rgb565_t'(pix);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ov_cam_window_gate.sv
// Per-frame x/y pixel counters with window crop and decimation test.
// Latency: keep is combinational from the registered counters.
// Backpressure: none; follows the camera timing.
module ov_cam_window_gate
    import ov_cam_pkg::*;
#(
    parameter int X_START  = 40,
    parameter int X_WIDTH  = 236,
    parameter int Y_START  = 0,
    parameter int Y_HEIGHT = 240,
    parameter int DEC_LOG2 = 0,
    parameter int CNT_W    = 16
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic clr,
    input  logic pix_vld,
    input  logic line_end,
    output logic keep
);

    localparam logic [CNT_W-1:0] X_LO     = CNT_W'(X_START);
    localparam logic [CNT_W-1:0] Y_LO     = CNT_W'(Y_START);
    localparam logic [CNT_W-1:0] X_W      = CNT_W'(X_WIDTH);
    localparam logic [CNT_W-1:0] Y_H      = CNT_W'(Y_HEIGHT);
    localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'((1 << DEC_LOG2) - 1);

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] dx;
    logic [CNT_W-1:0] dy;

    always_ff @(posedge pclk) begin
        if (!rst_n || clr) begin
            x <= '0;
            y <= '0;
        end else if (line_end) begin
            x <= '0;
            if (x != '0)
                y <= y + CNT_W'(1);
        end else if (pix_vld) begin
            x <= x + CNT_W'(1);
        end
    end

    // Offsets below the window start wrap to large values, so one unsigned compare covers both bounds.
    assign dx   = x - X_LO;
    assign dy   = y - Y_LO;
    assign keep = (dx < X_W) && (dy < Y_H) &&
                  ((dx & DEC_MASK) == '0) && ((dy & DEC_MASK) == '0);

endmodule

// File: rtl/ov_cam_window_capture.sv
// Camera byte-pair capture with window crop, decimation, format conversion and linear addressing.
// Latency: write_en two pclk edges after the second byte of a pixel is on the pins.
// Backpressure: none; the camera cannot be stalled, so every kept pixel is written immediately.
module ov_cam_window_capture
    import ov_cam_pkg::*;
#(
    parameter int X_START  = 40,
    parameter int X_WIDTH  = 236,
    parameter int Y_START  = 0,
    parameter int Y_HEIGHT = 240,
    parameter int DEC_LOG2 = 0,
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       data_out,
    output logic              write_en,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              line_err,
    output logic [7:0]        frame_cnt
);

    localparam int XK = (X_WIDTH + (1 << DEC_LOG2) - 1) >> DEC_LOG2;
    localparam int YK = (Y_HEIGHT + (1 << DEC_LOG2) - 1) >> DEC_LOG2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(XK * YK - 1);

    logic              s_vsync, s_href, d_vsync, d_href;
    logic [7:0]        s_data, hi_byte;
    logic              phase;
    cap_state_e        state;
    pix_mode_e         mode_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic              vs_rise, vs_fall, pix_vld, line_end, frame_start, keep, wr;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            s_vsync <= 1'b0;
            s_href  <= 1'b0;
            s_data  <= '0;
            d_vsync <= 1'b0;
            d_href  <= 1'b0;
        end else begin
            s_vsync <= vsync;
            s_href  <= href;
            s_data  <= data;
            d_vsync <= s_vsync;
            d_href  <= s_href;
        end
    end

    assign vs_rise     = s_vsync & ~d_vsync;
    assign vs_fall     = ~s_vsync & d_vsync;
    assign pix_vld     = s_href & phase;
    assign line_end    = d_href & ~s_href;
    assign frame_start = (state == ARMED) && vs_fall;
    assign wr          = (state == ACTIVE) && pix_vld && keep;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= '0;
        end else begin
            phase <= s_href ? ~phase : 1'b0;
            if (s_href && !phase)
                hi_byte <= s_data;
        end
    end

    ov_cam_window_gate #(
        .X_START  (X_START),
        .X_WIDTH  (X_WIDTH),
        .Y_START  (Y_START),
        .Y_HEIGHT (Y_HEIGHT),
        .DEC_LOG2 (DEC_LOG2),
        .CNT_W    (CNT_W)
    ) u_gate (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .clr      (frame_start),
        .pix_vld  (pix_vld),
        .line_end (line_end),
        .keep     (keep)
    );

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= MODE_RGB565;
            addr_cnt    <= '0;
            addr        <= '0;
            data_out    <= '0;
            write_en    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            line_err    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            write_en    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise && enable)
                        state <= ARMED;
                end
                ARMED: begin
                    if (vs_fall) begin
                        state    <= ACTIVE;
                        mode_q   <= pix_mode_e'(mode);
                        addr_cnt <= '0;
                        line_err <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (wr) begin
                        write_en <= 1'b1;
                        addr     <= addr_cnt;
                        data_out <= to_rgb565(mode_q, {hi_byte, s_data});
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end
                    if (line_end && phase)
                        line_err <= 1'b1;
                    // Completing the window outranks a coincident vsync rise.
                    if (wr && addr_cnt == LAST_ADDR) begin
                        state <= DONE;
                    end else if (vs_rise) begin
                        frame_abort <= 1'b1;
                        state       <= enable ? ARMED : IDLE;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov_cam_window_capture.sv
// Directed bench: a small-window instance (a) and a decimating instance (b) share one camera bus.
module tb_ov_cam_window_capture;

    logic       pclk   = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode   = 2'd0;
    logic       vsync  = 1'b0;
    logic       href   = 1'b0;
    logic [7:0] data   = 8'd0;

    logic [15:0] a_addr, a_data, b_addr, b_data;
    logic        a_we, a_done, a_abort, a_lerr;
    logic        b_we, b_done, b_abort, b_lerr;
    logic [7:0]  a_fcnt, b_fcnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_b[$];
    int done_a = 0, abort_a = 0, done_b = 0, abort_b = 0;
    int last_wr_a = 0, done_cyc_a = 0;

    ov_cam_window_capture #(
        .X_START(4), .X_WIDTH(6), .Y_START(1), .Y_HEIGHT(3),
        .DEC_LOG2(0), .ADDR_W(16), .CNT_W(16)
    ) dut_a (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .vsync(vsync), .href(href), .data(data),
        .addr(a_addr), .data_out(a_data), .write_en(a_we), .frame_done(a_done),
        .frame_abort(a_abort), .line_err(a_lerr), .frame_cnt(a_fcnt)
    );

    ov_cam_window_capture #(
        .X_START(0), .X_WIDTH(64), .Y_START(0), .Y_HEIGHT(8),
        .DEC_LOG2(1), .ADDR_W(16), .CNT_W(16)
    ) dut_b (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .vsync(vsync), .href(href), .data(data),
        .addr(b_addr), .data_out(b_data), .write_en(b_we), .frame_done(b_done),
        .frame_abort(b_abort), .line_err(b_lerr), .frame_cnt(b_fcnt)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (a_we) begin
            wr_a.push_back({a_addr, a_data});
            last_wr_a <= cyc;
        end
        if (a_done) begin
            done_a     <= done_a + 1;
            done_cyc_a <= cyc;
        end
        if (a_abort) abort_a <= abort_a + 1;
        if (b_we) wr_b.push_back({b_addr, b_data});
        if (b_done) done_b <= done_b + 1;
        if (b_abort) abort_b <= abort_b + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    function automatic logic [15:0] pv(input int line, input int col);
        return {8'(line), 8'(col)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'd0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic frame_start;
        vsync = 1'b1; tick(4);
        vsync = 1'b0; tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        href = 1'b1; data = b;
        tick(1);
    endtask

    task automatic line_gap;
        href = 1'b0; data = 8'd0;
        tick(4);
    endtask

    task automatic send_line(input int line, input int npix);
        for (int c = 0; c < npix; c++) begin
            send_byte(8'(line));
            send_byte(8'(c));
        end
        line_gap();
    endtask

    task automatic send_frame(input int nlines, input int npix);
        for (int l = 0; l < nlines; l++) send_line(l, npix);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; href = 1'b1; data = 8'hA5;
        tick(3);
        total++;
        if ({a_addr, a_data, a_we, a_done, a_abort, a_lerr, a_fcnt} !== '0) begin
            bad++;
            $display("FAIL reset_a got addr=%h data=%h we=%b done=%b abort=%b lerr=%b fcnt=%0d exp all 0",
                     a_addr, a_data, a_we, a_done, a_abort, a_lerr, a_fcnt);
        end
        total++;
        if ({b_addr, b_data, b_we, b_done, b_abort, b_lerr, b_fcnt} !== '0) begin
            bad++;
            $display("FAIL reset_b got addr=%h data=%h we=%b done=%b abort=%b lerr=%b fcnt=%0d exp all 0",
                     b_addr, b_data, b_we, b_done, b_abort, b_lerr, b_fcnt);
        end
        href = 1'b0;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_full_frame;
        int base, d0, ab0, n;
        logic [31:0] exp;
        do_reset();
        base = wr_a.size(); d0 = done_a; ab0 = abort_a;
        enable = 1'b1; mode = 2'd0;
        frame_start();
        send_frame(5, 12);
        tick(4);
        n = wr_a.size() - base;
        total++;
        if (n != 18) begin bad++; $display("FAIL full_count got=%0d exp=18", n); end
        for (int k = 0; k < n && k < 18; k++) begin
            exp = {16'(k), pv(1 + k / 6, 4 + k % 6)};
            total++;
            if (wr_a[base + k] !== exp) begin
                bad++;
                $display("FAIL full_write%0d got=%h exp=%h", k, wr_a[base + k], exp);
            end
        end
        total++;
        if (done_a - d0 != 1) begin bad++; $display("FAIL full_done got=%0d exp=1", done_a - d0); end
        total++;
        if (abort_a - ab0 != 0) begin bad++; $display("FAIL full_abort got=%0d exp=0", abort_a - ab0); end
        total++;
        if (a_fcnt !== 8'd1) begin bad++; $display("FAIL full_fcnt got=%0d exp=1", a_fcnt); end
        total++;
        if (done_cyc_a != last_wr_a + 1) begin
            bad++;
            $display("FAIL full_done_timing got=%0d exp=%0d", done_cyc_a, last_wr_a + 1);
        end
    endtask

    task automatic test_decimate;
        int base, d0, n;
        logic [31:0] exp;
        do_reset();
        base = wr_b.size(); d0 = done_b;
        enable = 1'b1; mode = 2'd0;
        frame_start();
        send_frame(8, 64);
        tick(4);
        n = wr_b.size() - base;
        total++;
        if (n != 128) begin bad++; $display("FAIL dec_count got=%0d exp=128", n); end
        for (int k = 0; k < n && k < 128; k++) begin
            exp = {16'(k), pv(2 * (k / 32), 2 * (k % 32))};
            total++;
            if (wr_b[base + k] !== exp) begin
                bad++;
                $display("FAIL dec_write%0d got=%h exp=%h", k, wr_b[base + k], exp);
            end
        end
        total++;
        if (done_b - d0 != 1) begin bad++; $display("FAIL dec_done got=%0d exp=1", done_b - d0); end
        total++;
        if (b_fcnt !== 8'd1) begin bad++; $display("FAIL dec_fcnt got=%0d exp=1", b_fcnt); end
    endtask

    task automatic test_yuv;
        int base;
        do_reset();
        base = wr_a.size();
        enable = 1'b1; mode = 2'd2;
        frame_start();
        mode = 2'd0;
        send_line(0, 12);
        for (int c = 0; c < 12; c++) begin
            send_byte((c % 2 == 0) ? 8'hF0 : 8'h10);
            send_byte(8'h80);
        end
        line_gap();
        total++;
        if (wr_a.size() - base < 2) begin
            bad++;
            $display("FAIL yuv_count got=%0d exp>=2", wr_a.size() - base);
        end else begin
            total++;
            if (wr_a[base][15:0] !== 16'hF79E) begin
                bad++;
                $display("FAIL yuv_pix0 got=%h exp=f79e", wr_a[base][15:0]);
            end
            total++;
            if (wr_a[base + 1][15:0] !== 16'h1082) begin
                bad++;
                $display("FAIL yuv_pix1 got=%h exp=1082", wr_a[base + 1][15:0]);
            end
        end
    endtask

    task automatic test_abort;
        int base, d0, ab0, n;
        do_reset();
        base = wr_a.size(); d0 = done_a; ab0 = abort_a;
        enable = 1'b1; mode = 2'd0;
        frame_start();
        send_line(0, 12);
        send_line(1, 12);
        vsync = 1'b1;
        tick(4);
        total++;
        if (abort_a - ab0 != 1) begin bad++; $display("FAIL abort_pulse got=%0d exp=1", abort_a - ab0); end
        total++;
        if (done_a - d0 != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_a - d0); end
        total++;
        if (a_fcnt !== 8'd0) begin bad++; $display("FAIL abort_fcnt got=%0d exp=0", a_fcnt); end
        total++;
        if (wr_a.size() - base != 6) begin
            bad++;
            $display("FAIL abort_writes got=%0d exp=6", wr_a.size() - base);
        end
        vsync = 1'b0;
        tick(4);
        base = wr_a.size();
        send_frame(5, 12);
        tick(4);
        n = wr_a.size() - base;
        total++;
        if (n != 18) begin
            bad++;
            $display("FAIL abort_next_count got=%0d exp=18", n);
        end else begin
            total++;
            if (wr_a[base][31:16] !== 16'd0) begin
                bad++;
                $display("FAIL abort_next_addr0 got=%0d exp=0", wr_a[base][31:16]);
            end
            total++;
            if (wr_a[base + 17][31:16] !== 16'd17) begin
                bad++;
                $display("FAIL abort_next_addr17 got=%0d exp=17", wr_a[base + 17][31:16]);
            end
        end
        total++;
        if (a_fcnt !== 8'd1) begin bad++; $display("FAIL abort_next_fcnt got=%0d exp=1", a_fcnt); end
    endtask

    task automatic test_line_err;
        int base, n;
        do_reset();
        base = wr_a.size();
        enable = 1'b1; mode = 2'd0;
        frame_start();
        send_line(0, 12);
        total++;
        if (a_lerr !== 1'b0) begin bad++; $display("FAIL lerr_clean got=%b exp=0", a_lerr); end
        for (int c = 0; c < 6; c++) begin
            send_byte(8'd1);
            send_byte(8'(c));
        end
        send_byte(8'h77);
        line_gap();
        total++;
        if (a_lerr !== 1'b1) begin bad++; $display("FAIL lerr_set got=%b exp=1", a_lerr); end
        n = wr_a.size() - base;
        total++;
        if (n != 2) begin bad++; $display("FAIL lerr_line_writes got=%0d exp=2", n); end
        send_line(2, 12);
        n = wr_a.size() - base;
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL lerr_realign_count got=%0d exp=8", n);
        end else begin
            total++;
            if (wr_a[base + 2] !== {16'd2, pv(2, 4)}) begin
                bad++;
                $display("FAIL lerr_realign_pix got=%h exp=%h", wr_a[base + 2], {16'd2, pv(2, 4)});
            end
        end
        vsync = 1'b1;
        tick(4);
        total++;
        if (a_lerr !== 1'b1) begin bad++; $display("FAIL lerr_sticky got=%b exp=1", a_lerr); end
        vsync = 1'b0;
        tick(4);
        total++;
        if (a_lerr !== 1'b0) begin bad++; $display("FAIL lerr_clear got=%b exp=0", a_lerr); end
    endtask

    task automatic test_last_vs;
        int base, d0, ab0;
        do_reset();
        base = wr_a.size(); d0 = done_a; ab0 = abort_a;
        enable = 1'b1; mode = 2'd0;
        frame_start();
        send_frame(3, 12);
        for (int c = 0; c < 10; c++) begin
            send_byte(8'd3);
            if (c == 9) vsync = 1'b1;
            send_byte(8'(c));
        end
        line_gap();
        vsync = 1'b0;
        tick(4);
        total++;
        if (wr_a.size() - base != 18) begin
            bad++;
            $display("FAIL lastvs_count got=%0d exp=18", wr_a.size() - base);
        end
        total++;
        if (done_a - d0 != 1) begin bad++; $display("FAIL lastvs_done got=%0d exp=1", done_a - d0); end
        total++;
        if (abort_a - ab0 != 0) begin bad++; $display("FAIL lastvs_abort got=%0d exp=0", abort_a - ab0); end
    endtask

    task automatic test_reset_mid;
        int base, n;
        do_reset();
        enable = 1'b1; mode = 2'd0;
        frame_start();
        send_line(0, 12);
        for (int c = 0; c < 12; c++) begin
            if (c == 6) begin
                rst_n = 1'b0;
                send_byte(8'd1);
                rst_n = 1'b1;
                total++;
                if ({a_addr, a_data, a_we, a_done, a_abort, a_lerr, a_fcnt} !== '0) begin
                    bad++;
                    $display("FAIL midrst_outputs got addr=%h data=%h we=%b fcnt=%0d exp all 0",
                             a_addr, a_data, a_we, a_fcnt);
                end
            end else begin
                send_byte(8'd1);
            end
            send_byte(8'(c));
        end
        line_gap();
        base = wr_a.size();
        send_line(2, 12);
        send_line(3, 12);
        send_line(4, 12);
        total++;
        if (wr_a.size() - base != 0) begin
            bad++;
            $display("FAIL midrst_no_writes got=%0d exp=0", wr_a.size() - base);
        end
        base = wr_a.size();
        frame_start();
        send_frame(5, 12);
        tick(4);
        n = wr_a.size() - base;
        total++;
        if (n != 18) begin
            bad++;
            $display("FAIL midrst_next_count got=%0d exp=18", n);
        end else begin
            total++;
            if (wr_a[base] !== {16'd0, pv(1, 4)}) begin
                bad++;
                $display("FAIL midrst_next_first got=%h exp=%h", wr_a[base], {16'd0, pv(1, 4)});
            end
        end
        total++;
        if (a_fcnt !== 8'd1) begin bad++; $display("FAIL midrst_fcnt got=%0d exp=1", a_fcnt); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_decimate();
        test_yuv();
        test_abort();
        test_line_err();
        test_last_vs();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
